multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state sequencer that drives the shared multicycle processor datapath (single memory, single ALU, instruction register) through fetch, decode, execute, memory and write-back steps for the RV32I subset R-type, I-type ALU, LW, SW and BEQ. It replaces the one-shot combinational controller of the single-cycle core and sits beside the existing ALU controller, which still decodes func3/func7 from `alu_op`. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  7  instruction register bits [6:0], valid from DECODE onward
- `mem_ready`  in  1  memory completes current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load qualified by datapath `zero_flag`
- `pc_source`  out  1  0 = ALU result, 1 = ALUOut register
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read` / `mem_write`  out  1  memory strobes
- `ir_write`  out  1  load IR and old-PC register
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write
- `alu_src_a`  out  2  00 = PC, 01 = old PC, 10 = rs1
- `alu_src_b`  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- `instr_done`  out  1  one-cycle pulse in final cycle of each instruction
- `illegal`  out  1  only with ILLEGAL_TRAP_EN (see Configuration)

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH (+ HALT with macro). 4-bit state register; outputs decoded from state (and `mem_ready` where noted). Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0; ir_write=pc_write=mem_ready. Stays until mem_ready=1, then DECODE.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next by opcode: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; other -> see Configuration.
- MEM_ADDR: alu_src_a=10, alu_src_b=10, alu_op=00; -> MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, iord=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1; -> FETCH.
- MEM_WR: mem_write=1, iord=1; instr_done=mem_ready; on mem_ready -> FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; -> ALU_WB. EXEC_I: same with alu_src_b=10; -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1; -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1; -> FETCH.
- `mem_ready` is ignored outside FETCH, MEM_RD, MEM_WR.

## Timing
- While `rst`=1: state=FETCH and every output forced 0 (including `illegal`). First FETCH cycle is the first clock edge after deassertion.
- Latency with mem_ready=1 throughout: BEQ 3, R/I 4, SW 4, LW 5 cycles. Each low `mem_ready` cycle in a wait state adds one cycle.
- Exactly one `instr_done` pulse per instruction; pc_write and pc_write_cond never both 1; mem_read and mem_write never both 1.
- Reset asserted mid-instruction aborts immediately; no partial write-back afterwards.

## Configuration
- `ILLEGAL_TRAP_EN` defined: unrecognised opcode in DECODE -> HALT; HALT drives all enables 0 and `illegal`=1, exits only by reset. Port `illegal` exists.
- Undefined: unrecognised opcode treated as NOP; DECODE pulses instr_done=1 and returns to FETCH (2 cycles). No `illegal` port.

## Test plan
- Reset release, mem_ready=1, opcode=0110011 -> states FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 in cycle 4, instr_done once, back to FETCH cycle 5.
- LW (0000011) with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_to_reg=1, reg_write=1 only in MEM_WB.
- SW (0100011), mem_ready=1 -> mem_write=1, iord=1 in cycle 4; reg_write never 1.
- BEQ (1100011) -> cycle 3 pc_write_cond=1, pc_source=1, alu_op=01; 3 cycles total.
- FETCH with mem_ready=0 for 3 cycles -> ir_write/pc_write stay 0, state holds; assert on first mem_ready=1.
- opcode=1111111: with ILLEGAL_TRAP_EN -> illegal=1 held 10+ cycles until rst; without -> instr_done in DECODE, FETCH next. Mid-LW reset -> all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   FSM sequencer for the shared multicycle RV32I datapath (R-type, I-type ALU,
//   LW, SW, BEQ). Walks each instruction through fetch, decode, execute,
//   memory and write-back steps. Memory steps stall until mem_ready.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset; forces FETCH and all outputs 0
//   opcode[6:0]    instruction register opcode field (valid from DECODE onward)
//   mem_ready      memory finishes the current read/write this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by the datapath zero flag
//   pc_source      0 = ALU result, 1 = ALUOut register
//   iord           memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       load IR and old-PC register
//   mem_to_reg     write-back source: 0 = ALUOut, 1 = MDR
//   reg_write      register file write enable
//   alu_src_a[1:0] 00 = PC, 01 = old PC, 10 = rs1
//   alu_src_b[1:0] 00 = rs2, 01 = constant 4, 10 = immediate
//   alu_op[1:0]    00 = add, 01 = subtract, 10 = funct-decoded
//   instr_done     one-cycle pulse in the final cycle of each instruction
//   illegal        (ILLEGAL_TRAP_EN only) held high in HALT until reset
//
// Configuration macro
//   ILLEGAL_TRAP_EN  defined: unknown opcode in DECODE traps to HALT.
//                    undefined: unknown opcode retires as a 2-cycle NOP.

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_HALT
  } state_e;

  state_e state_q, state_d;
  logic   op_known;

  assign op_known = (opcode == OP_LOAD)  || (opcode == OP_STORE) ||
                    (opcode == OP_RTYPE) || (opcode == OP_ITYPE) ||
                    (opcode == OP_BRANCH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_HALT;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Outputs decode combinationally from state because several of them must
  // follow mem_ready within the same cycle; rst gates everything to 0 so an
  // abort takes effect before the next edge.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal       = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
`ifndef ILLEGAL_TRAP_EN
          instr_done = ~op_known;
`endif
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b10;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
          instr_done    = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // op_known only matters for the NOP path.
  logic unused_op_known;
  assign unused_op_known = op_known;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, instr_done;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;

  // Observed control word, MSB..LSB.
  logic [15:0] obs;
  assign obs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                instr_done};

  localparam logic [15:0] MASK_FETCH = 16'h8200;  // pc_write | ir_write
  localparam logic [15:0] MASK_DONE  = 16'h0001;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    string       name;
    logic [15:0] word;     // outputs with mem_ready low
    logic [15:0] mr_mask;  // outputs that follow mem_ready
    bit          waits;    // step holds while mem_ready is low
  } step_t;

  step_t plan[$];

  function automatic logic [15:0] cw(bit pcw, bit pcc, bit pcs, bit io, bit mr,
                                     bit mw, bit irw, bit m2r, bit rw,
                                     logic [1:0] a, logic [1:0] b,
                                     logic [1:0] op, bit done);
    return {pcw, pcc, pcs, io, mr, mw, irw, m2r, rw, a, b, op, done};
  endfunction

  task automatic add(input string n, input logic [15:0] w, input logic [15:0] m,
                     input bit wt);
    step_t s;
    s.name = n; s.word = w; s.mr_mask = m; s.waits = wt;
    plan.push_back(s);
  endtask

  function automatic bit is_known(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT || op == BEQ;
  endfunction

  // Instruction-level description of the expected control sequence.
  task automatic build_plan(input logic [6:0] op);
    plan.delete();
    add("FETCH", cw(0,0,0,0,1,0,0,0,0,2'b00,2'b01,2'b00,0), MASK_FETCH, 1);
    if (is_known(op))
      add("DECODE", cw(0,0,0,0,0,0,0,0,0,2'b01,2'b10,2'b00,0), '0, 0);
    else
      add("DECODE_NOP", cw(0,0,0,0,0,0,0,0,0,2'b01,2'b10,2'b00,1), '0, 0);
    case (op)
      LW: begin
        add("MEM_ADDR", cw(0,0,0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0), '0, 0);
        add("MEM_RD",   cw(0,0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,0), '0, 1);
        add("MEM_WB",   cw(0,0,0,0,0,0,0,1,1,2'b00,2'b00,2'b00,1), '0, 0);
      end
      SW: begin
        add("MEM_ADDR", cw(0,0,0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0), '0, 0);
        add("MEM_WR",   cw(0,0,0,1,0,1,0,0,0,2'b00,2'b00,2'b00,0), MASK_DONE, 1);
      end
      RT: begin
        add("EXEC_R", cw(0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b10,0), '0, 0);
        add("ALU_WB", cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,1), '0, 0);
      end
      IT: begin
        add("EXEC_I", cw(0,0,0,0,0,0,0,0,0,2'b10,2'b10,2'b10,0), '0, 0);
        add("ALU_WB", cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,1), '0, 0);
      end
      BEQ: add("BRANCH", cw(0,1,1,0,0,0,0,0,0,2'b10,2'b00,2'b01,1), '0, 0);
      default: ;
    endcase
  endtask

  function automatic int unsigned base_latency(input logic [6:0] op);
    case (op)
      LW:          return 5;
      SW, RT, IT:  return 4;
      BEQ:         return 3;
      default:     return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called at posedge+1 with the FSM in FETCH; returns at posedge+1 after the
  // instruction retires. lows_* = low mem_ready cycles in fetch / memory wait.
  task automatic run_instr(input logic [6:0] op, input int unsigned lows_fetch,
                           input int unsigned lows_mem);
    int unsigned idx, cyc, low_seen, dones, lows, exp_lat;
    logic [15:0] e;
    bit wt;
    string tag;
    build_plan(op);
    opcode = op;
    idx = 0; cyc = 0; low_seen = 0; dones = 0;
    while (idx < plan.size() && cyc < 64) begin
      wt   = plan[idx].waits;
      lows = (plan[idx].name == "FETCH") ? lows_fetch : lows_mem;
      if (wt) mem_ready = (low_seen >= lows);
      else    mem_ready = 1'($urandom_range(0, 1));
      #1;
      e   = plan[idx].word | (mem_ready ? plan[idx].mr_mask : '0);
      tag = $sformatf("op%b/%s/c%0d", op, plan[idx].name, cyc + 1);
      check(tag, obs, e);
      if (instr_done === 1'b1) dones++;
      cyc++;
      if (wt && !mem_ready) low_seen++;
      else begin idx++; low_seen = 0; end
      @(posedge clk); #1;
    end
    exp_lat = base_latency(op) + lows_fetch + ((op == LW || op == SW) ? lows_mem : 0);
    check($sformatf("op%b/latency", op), 16'(cyc), 16'(exp_lat));
    check($sformatf("op%b/done_count", op), 16'(dones), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops[5];
    logic [6:0] op;
    rst = 1'b1; mem_ready = 1'b1; opcode = RT;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BEQ;

    // Reset: every output low regardless of mem_ready.
    #2 check("reset_async", obs, '0);
    repeat (3) @(posedge clk);
    #1 check("reset_held", obs, '0);
`ifdef ILLEGAL_TRAP_EN
    check("reset_illegal", 16'(illegal), 16'd0);
`endif
    rst = 1'b0;

    // Directed: R-type, LW with 2 stall cycles, SW, BEQ, I-type, fetch stall.
    run_instr(RT, 0, 0);
    run_instr(LW, 0, 2);
    run_instr(SW, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(IT, 0, 0);
    run_instr(RT, 3, 0);
    run_instr(SW, 1, 3);

`ifndef ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 0, 0);
`endif

    // Randomised instruction stream with random stalls.
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 4)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 5) == 0) begin
        op = 7'($urandom);
        while (is_known(op)) op = 7'($urandom);
      end
`endif
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a load: outputs drop at once, restart in FETCH.
    build_plan(LW);
    opcode = LW; mem_ready = 1'b1;
    #1 check("midlw_fetch", obs, plan[0].word | plan[0].mr_mask);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1 check("midlw_memrd", obs, plan[3].word);
    rst = 1'b1;
    #1 check("midlw_abort", obs, '0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1 check("midlw_abort_held", obs, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(RT, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    // Unknown opcode traps: illegal held, all enables low, until reset.
    opcode = 7'b1111111; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halt_outputs/%0d", k), obs, '0);
      check($sformatf("halt_illegal/%0d", k), 16'(illegal), 16'd1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1 check("halt_reset_illegal", 16'(illegal), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(BEQ, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
